// File: rtl/codec_cfg_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: FSM state
// encoding, codec register addresses and the fixed configuration words.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PULSE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_FIN   = 3'd5
    } cfg_state_e;

    localparam logic [6:0] REG_LEFT_LINE_IN  = 7'h00;
    localparam logic [6:0] REG_RIGHT_LINE_IN = 7'h01;
    localparam logic [6:0] REG_LEFT_HP_OUT   = 7'h02;
    localparam logic [6:0] REG_RIGHT_HP_OUT  = 7'h03;
    localparam logic [6:0] REG_ANALOG_PATH   = 7'h04;
    localparam logic [6:0] REG_DIGITAL_PATH  = 7'h05;
    localparam logic [6:0] REG_POWER_DOWN    = 7'h06;
    localparam logic [6:0] REG_DIGITAL_IF    = 7'h07;
    localparam logic [6:0] REG_SAMPLING      = 7'h08;
    localparam logic [6:0] REG_ACTIVE        = 7'h09;
    localparam logic [6:0] REG_RESET         = 7'h0F;

    // The I2C master expects the 7-bit register address above 9 data bits.
    function automatic logic [15:0] cfg_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

    localparam logic [15:0] W_CODEC_RESET    = cfg_word(REG_RESET,         9'h000);
    localparam logic [15:0] W_LEFT_LINE_IN   = cfg_word(REG_LEFT_LINE_IN,  9'h017);
    localparam logic [15:0] W_RIGHT_LINE_IN  = cfg_word(REG_RIGHT_LINE_IN, 9'h017);
    localparam logic [15:0] W_LEFT_HP_OUT    = cfg_word(REG_LEFT_HP_OUT,   9'h079);
    localparam logic [15:0] W_RIGHT_HP_OUT   = cfg_word(REG_RIGHT_HP_OUT,  9'h079);
    localparam logic [15:0] W_ANALOG_PATH    = cfg_word(REG_ANALOG_PATH,   9'h012);
    localparam logic [15:0] W_DIGITAL_PATH   = cfg_word(REG_DIGITAL_PATH,  9'h000);
    localparam logic [15:0] W_POWER_ON       = cfg_word(REG_POWER_DOWN,    9'h000);
    localparam logic [15:0] W_DIGITAL_IF     = cfg_word(REG_DIGITAL_IF,    9'h001);
    localparam logic [15:0] W_SAMPLING       = cfg_word(REG_SAMPLING,      9'h000);
    localparam logic [15:0] W_ACTIVE         = cfg_word(REG_ACTIVE,        9'h001);

endpackage

// File: rtl/codec_config_rom.sv
// Combinational lookup of the WM8731 configuration table; indices past the
// last entry read as zero.
module codec_config_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] word
);

    always_comb begin
        word = 16'h0000;
        case (index)
            4'd0:    word = W_CODEC_RESET;
            4'd1:    word = W_LEFT_LINE_IN;
            4'd2:    word = W_RIGHT_LINE_IN;
            4'd3:    word = W_LEFT_HP_OUT;
            4'd4:    word = W_RIGHT_HP_OUT;
            4'd5:    word = W_ANALOG_PATH;
            4'd6:    word = W_DIGITAL_PATH;
            4'd7:    word = W_POWER_ON;
            4'd8:    word = W_DIGITAL_IF;
            4'd9:    word = W_SAMPLING;
            4'd10:   word = W_ACTIVE;
            default: word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the WM8731 configuration table, handing each word to the I2C master
// with a start pulse and a fixed transfer window, then reports DONE.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS     = 11,
    parameter int PULSE_CYCLES = 4,
    parameter int XFER_CYCLES  = 96,
    parameter int GAP_CYCLES   = 16,
    parameter int AUTO_START   = 1
) (
    input  logic        CLOCK50M,
    input  logic        RESET,
    input  logic        START,
    output logic [15:0] message,
    output logic        InitialiseTransfer,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  INDEX,
    output cfg_state_e  dbg_state
);

    // Handshake with the I2C master: message becomes valid one cycle before
    // InitialiseTransfer rises and stays constant until the end of the gap.
    // The master has no ready or completion signal, so the window is timed.

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] XFER_LAST  = 8'(XFER_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] LAST_INDEX = 4'(NUM_REGS - 1);

    cfg_state_e  state, state_nxt;
    logic [7:0]  timer, timer_nxt;
    logic [3:0]  index_nxt;
    logic        start_q;
    logic        start_rise;
    logic [15:0] rom_word;

    assign start_rise = START & ~start_q;
    assign dbg_state  = state;

    // Looked up with the next index so the word is already on message
    // during the LOAD cycle, ahead of the pulse edge.
    codec_config_rom u_rom (
        .index (index_nxt),
        .word  (rom_word)
    );

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        index_nxt = INDEX;
        case (state)
            ST_IDLE: begin
                if (AUTO_START != 0 || start_rise) begin
                    state_nxt = ST_LOAD;
                    index_nxt = '0;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_PULSE;
                timer_nxt = '0;
            end
            ST_PULSE: begin
                timer_nxt = timer + 8'd1;
                if (timer == PULSE_LAST) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // timer runs on from the pulse rise, so this bounds the whole window
                if (timer == XFER_LAST) begin
                    state_nxt = ST_GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            ST_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nxt = '0;
                    if (INDEX == LAST_INDEX) begin
                        state_nxt = ST_FIN;
                    end else begin
                        state_nxt = ST_LOAD;
                        index_nxt = INDEX + 4'd1;
                    end
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            ST_FIN: begin
                if (start_rise) begin
                    state_nxt = ST_LOAD;
                    index_nxt = '0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK50M or negedge RESET) begin
        if (!RESET) begin
            state              <= ST_IDLE;
            timer              <= '0;
            INDEX              <= '0;
            message            <= '0;
            InitialiseTransfer <= 1'b0;
            BUSY               <= 1'b0;
            DONE               <= 1'b0;
            start_q            <= 1'b0;
        end else begin
            state              <= state_nxt;
            timer              <= timer_nxt;
            INDEX              <= index_nxt;
            start_q            <= START;
            if (state_nxt == ST_LOAD) message <= rom_word;
            InitialiseTransfer <= (state_nxt == ST_PULSE);
            BUSY               <= (state_nxt == ST_LOAD) || (state_nxt == ST_PULSE) ||
                                  (state_nxt == ST_WAIT) || (state_nxt == ST_GAP);
            DONE               <= (state_nxt == ST_FIN);
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Randomised bench for codec_config_sequencer: expected words queued per run,
// a negedge monitor checks order, timing and message stability.
module tb_codec_config_sequencer;
    import codec_cfg_pkg::*;

    logic        CLOCK50M = 1'b0;
    logic        RESET    = 1'b0;
    logic        START    = 1'b0;
    logic [15:0] message;
    logic        InitialiseTransfer;
    logic        BUSY;
    logic        DONE;
    logic [3:0]  INDEX;
    cfg_state_e  dbg_state;

    codec_config_sequencer dut (
        .CLOCK50M           (CLOCK50M),
        .RESET              (RESET),
        .START              (START),
        .message            (message),
        .InitialiseTransfer (InitialiseTransfer),
        .BUSY               (BUSY),
        .DONE               (DONE),
        .INDEX              (INDEX),
        .dbg_state          (dbg_state)
    );

    // clock / reset
    always #10 CLOCK50M = ~CLOCK50M;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // reference model: the register table and the timing rules
    localparam int ENTRIES      = 11;
    localparam int PERIOD       = 1 + 96 + 16;
    localparam int PULSE_WIDTH  = 4;
    localparam int RUN_TO_DONE  = ENTRIES * PERIOD - 1;

    logic [15:0] ref_table [ENTRIES] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                         16'h0812, 16'h0A00, 16'h0C00, 16'h0E01, 16'h1000,
                                         16'h1201};

    logic [19:0] exp_q[$];
    int check_count = 0;
    int pass_count  = 0;
    int pulse_count = 0;

    task automatic check(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) pass_count++;
        else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    endtask

    task automatic push_run();
        for (int i = 0; i < ENTRIES; i++) exp_q.push_back({4'(i), ref_table[i]});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLOCK50M);
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (!DONE && n < bound) begin
            @(posedge CLOCK50M);
            #1;
            n++;
        end
        check(name, int'(DONE), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_message"}, int'(message), 0);
        check({tag, "_pulse"},   int'(InitialiseTransfer), 0);
        check({tag, "_busy"},    int'(BUSY), 0);
        check({tag, "_done"},    int'(DONE), 0);
        check({tag, "_index"},   int'(INDEX), 0);
    endtask

    // monitor / scoreboard
    initial begin : monitor
        int          cyc = 0;
        int          last_rise = 0;
        int          first_rise = 0;
        int          msg_change_cyc = 0;
        int          rises_in_run = 0;
        logic        prev_it = 1'b0;
        logic        prev_done = 1'b0;
        logic [15:0] prev_msg = '0;
        logic [19:0] e;
        forever begin
            @(negedge CLOCK50M);
            cyc++;
            if (!RESET) begin
                prev_it      = 1'b0;
                prev_done    = 1'b0;
                prev_msg     = '0;
                rises_in_run = 0;
            end else begin
                if (message != prev_msg) begin
                    if (rises_in_run > 0) check("msg_change_time", cyc - last_rise, PERIOD - 1);
                    msg_change_cyc = cyc;
                end
                if (InitialiseTransfer && !prev_it) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_message", int'(message), int'(e[15:0]));
                        check("pulse_index", int'(INDEX), int'(e[19:16]));
                    end
                    check("busy_at_pulse", int'(BUSY), 1);
                    check("load_to_pulse", cyc - msg_change_cyc, 1);
                    if (rises_in_run > 0) check("pulse_interval", cyc - last_rise, PERIOD);
                    else first_rise = cyc;
                    last_rise = cyc;
                    rises_in_run++;
                    pulse_count++;
                end
                if (!InitialiseTransfer && prev_it) check("pulse_width", cyc - last_rise, PULSE_WIDTH);
                if (DONE && !prev_done) begin
                    check("done_latency", cyc - first_rise, RUN_TO_DONE);
                    check("run_pulses", rises_in_run, ENTRIES);
                    check("done_queue_empty", exp_q.size(), 0);
                    check("busy_at_done", int'(BUSY), 0);
                    rises_in_run = 0;
                end
                prev_it   = InitialiseTransfer;
                prev_done = DONE;
                prev_msg  = message;
            end
        end
    end

    // stimulus
    initial begin : stimulus
        int off;
        int w;
        wait_cycles(3);
        #1;
        check_all_zero("reset");

        // run 1: auto start, spurious START during entry 5
        push_run();
        @(negedge CLOCK50M);
        #2 RESET = 1'b1;
        @(posedge CLOCK50M);
        #1;
        check("first_load_message", int'(message), 16'h1E00);
        check("first_load_pulse", int'(InitialiseTransfer), 0);
        check("first_load_busy", int'(BUSY), 1);
        @(posedge CLOCK50M);
        #1;
        check("first_pulse_rise", int'(InitialiseTransfer), 1);
        off = $urandom_range(10, 80);
        w   = $urandom_range(1, 5);
        wait_cycles(5 * PERIOD + off);
        #2 START = 1'b1;
        wait_cycles(w);
        #2 START = 1'b0;
        wait_done("run1_done", 1500);
        wait_cycles($urandom_range(5, 20));
        #1;
        check("idle_done_held", int'(DONE), 1);
        check("idle_busy_low", int'(BUSY), 0);
        check("run1_pulse_total", pulse_count, 11);

        // run 2: START rises and stays high
        push_run();
        #1 START = 1'b1;
        @(posedge CLOCK50M);
        #1;
        check("rerun_done_cleared", int'(DONE), 0);
        check("rerun_index", int'(INDEX), 0);
        check("rerun_busy", int'(BUSY), 1);
        check("rerun_message", int'(message), 16'h1E00);
        wait_done("run2_done", 1500);
        wait_cycles(300);
        #1;
        check("held_start_done", int'(DONE), 1);
        check("held_start_busy", int'(BUSY), 0);
        check("no_second_rerun", pulse_count, 22);

        // run 3: reset during the WAIT of entry 7
        START = 1'b0;
        wait_cycles(3);
        push_run();
        #1 START = 1'b1;
        @(posedge CLOCK50M);
        #1 START = 1'b0;
        off = $urandom_range(5, 80);
        wait_cycles(1 + 7 * PERIOD + off);
        #3 RESET = 1'b0;
        #1;
        check_all_zero("async_reset");
        check("pulses_before_reset", pulse_count, 30);
        exp_q.delete();
        wait_cycles($urandom_range(2, 6));

        // run 4: restart after reset release
        push_run();
        @(negedge CLOCK50M);
        #2 RESET = 1'b1;
        @(posedge CLOCK50M);
        #1;
        check("restart_message", int'(message), 16'h1E00);
        check("restart_index", int'(INDEX), 0);
        check("restart_busy", int'(BUSY), 1);
        wait_done("run4_done", 1500);
        wait_cycles(10);
        check("final_pulse_total", pulse_count, 41);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
